// File: rtl/square_wave_meas_multi_if.sv
// square_wave_meas_multi_if: start/result bus between the wave meter and its register/MCU side.
interface square_wave_meas_multi_if #(
    parameter int CH_NUM = 2,
    parameter int CNT_W  = 32,
    parameter int N_W    = 16
);
    logic                     start;
    logic [N_W-1:0]           n_cycles;
    logic                     busy;
    logic                     done;
    logic [CH_NUM*CNT_W-1:0]  period_total;
    logic [CH_NUM*CNT_W-1:0]  high_total;
    logic [CH_NUM-1:0]        ch_valid;
    logic [CH_NUM-1:0]        ch_timeout;
    logic [CH_NUM-1:0]        ch_ovf;
    modport master (
        output start, n_cycles,
        input  busy, done, period_total, high_total, ch_valid, ch_timeout, ch_ovf
    );
    modport slave (
        input  start, n_cycles,
        output busy, done, period_total, high_total, ch_valid, ch_timeout, ch_ovf
    );
endinterface

// File: rtl/square_wave_meas_multi.sv
// square_wave_meas_multi: per-channel equal-precision period and high-time meter over N input periods.
module square_wave_meas_multi #(
    parameter int SYS_CLK_FREQ = 200_000_000,
    parameter int CH_NUM       = 2,
    parameter int CNT_W        = 32,
    parameter int N_W          = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT_CLKS = SYS_CLK_FREQ / 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [CH_NUM-1:0] wave_in,
    square_wave_meas_multi_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS, FIN} state_t;
    localparam int IW = $clog2(TIMEOUT_CLKS + 1) + 1;

    logic [SYNC_STAGES-1:0] sync_q [CH_NUM];
    logic [CH_NUM-1:0]      hist, lvl, rise, pwrap, hwrap, valid, tout, ovf;
    state_t                 st [CH_NUM];
    logic [CNT_W-1:0]       pcnt [CH_NUM], hcnt [CH_NUM], pnext [CH_NUM], hnext [CH_NUM];
    logic [CNT_W-1:0]       ptot [CH_NUM], htot [CH_NUM];
    logic [N_W-1:0]         ecnt [CH_NUM];
    logic [IW-1:0]          icnt [CH_NUM];
    logic [N_W-1:0]         n_eff;
    logic                   busy, done, accept, all_fin;
    logic [CH_NUM*CNT_W-1:0] ptot_f, htot_f;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hist <= '0;
            for (int i = 0; i < CH_NUM; i++) sync_q[i] <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], wave_in[i]};
                hist[i]   <= sync_q[i][SYNC_STAGES-1];
            end
        end
    end

    // Next-value forms saturate at all-ones; the wrap flags mark an attempted overflow.
    always_comb begin
        all_fin = 1'b1;
        lvl     = '0;
        rise    = '0;
        pwrap   = '0;
        hwrap   = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            lvl[i]   = sync_q[i][SYNC_STAGES-1];
            rise[i]  = lvl[i] & ~hist[i];
            pwrap[i] = &pcnt[i];
            hwrap[i] = (&hcnt[i]) & lvl[i];
            pnext[i] = pwrap[i] ? pcnt[i] : pcnt[i] + 1'b1;
            hnext[i] = (hwrap[i] || !lvl[i]) ? hcnt[i] : hcnt[i] + 1'b1;
            if (st[i] != FIN) all_fin = 1'b0;
        end
    end

    assign accept = bus.start & ~busy & ~done;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            n_eff <= '0;
            valid <= '0;
            tout  <= '0;
            ovf   <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                st[i]   <= IDLE;
                pcnt[i] <= '0;
                hcnt[i] <= '0;
                ecnt[i] <= '0;
                icnt[i] <= '0;
                ptot[i] <= '0;
                htot[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy  <= 1'b1;
                n_eff <= (bus.n_cycles == '0) ? N_W'(1) : bus.n_cycles;
                valid <= '0;
                tout  <= '0;
                ovf   <= '0;
            end else if (busy && all_fin) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            for (int i = 0; i < CH_NUM; i++) begin
                if (accept) begin
                    st[i]   <= ARM;
                    ptot[i] <= '0;
                    htot[i] <= '0;
                    icnt[i] <= '0;
                end else if (busy && all_fin) begin
                    st[i] <= IDLE;
                end else if (st[i] == ARM || st[i] == MEAS) begin
                    icnt[i] <= rise[i] ? '0 : icnt[i] + 1'b1;
                    if (st[i] == ARM && rise[i]) begin
                        st[i]   <= MEAS;
                        pcnt[i] <= '0;
                        hcnt[i] <= '0;
                        ecnt[i] <= '0;
                    end else if (st[i] == MEAS) begin
                        pcnt[i] <= pnext[i];
                        hcnt[i] <= hnext[i];
                        if (pwrap[i] || hwrap[i]) ovf[i] <= 1'b1;
                        // Latching the next values includes the terminating clock, so both totals span exactly N periods.
                        if (rise[i]) begin
                            ecnt[i] <= ecnt[i] + 1'b1;
                            if (ecnt[i] + 1'b1 == n_eff) begin
                                ptot[i]  <= pnext[i];
                                htot[i]  <= hnext[i];
                                valid[i] <= 1'b1;
                                st[i]    <= FIN;
                            end
                        end
                    end
                    if (!rise[i] && icnt[i] == IW'(TIMEOUT_CLKS - 1)) begin
                        tout[i]  <= 1'b1;
                        valid[i] <= 1'b0;
                        ptot[i]  <= '0;
                        htot[i]  <= '0;
                        st[i]    <= FIN;
                    end
                end
            end
        end
    end

    always_comb begin
        ptot_f = '0;
        htot_f = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            ptot_f[i*CNT_W +: CNT_W] = ptot[i];
            htot_f[i*CNT_W +: CNT_W] = htot[i];
        end
    end

    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.period_total = ptot_f;
    assign bus.high_total   = htot_f;
    assign bus.ch_valid     = valid;
    assign bus.ch_timeout   = tout;
    assign bus.ch_ovf       = ovf;
endmodule

// File: tb/tb_square_wave_meas_multi.sv
// tb_square_wave_meas_multi: scoreboard bench for the wave meter, with a narrow-counter instance for saturation.
module tb_square_wave_meas_multi;
    typedef struct {
        logic [63:0] ptot;
        logic [63:0] htot;
        logic [1:0]  valid;
        logic [1:0]  tout;
        logic [1:0]  ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] wave = 2'b00;
    int per [2] = '{100, 250};
    int hi  [2] = '{30, 125};
    bit en  [2] = '{1'b1, 1'b1};
    int ph  [2] = '{0, 0};
    int vectors = 0;
    int miscompares = 0;
    exp_t sb [$];
    exp_t osb [$];
    exp_t me;

    square_wave_meas_multi_if #(.CH_NUM(2), .CNT_W(32), .N_W(16)) m ();
    square_wave_meas_multi_if #(.CH_NUM(1), .CNT_W(8), .N_W(16)) o ();

    square_wave_meas_multi #(.CH_NUM(2), .CNT_W(32), .N_W(16), .SYNC_STAGES(2), .TIMEOUT_CLKS(5000)) u_dut (
        .sys_clk(clk), .sys_rst(rst), .wave_in(wave), .bus(m)
    );
    square_wave_meas_multi #(.CH_NUM(1), .CNT_W(8), .N_W(16), .SYNC_STAGES(2), .TIMEOUT_CLKS(5000)) u_ovf (
        .sys_clk(clk), .sys_rst(rst), .wave_in(wave[0:0]), .bus(o)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                ph[c] = (ph[c] + 1 >= per[c]) ? 0 : ph[c] + 1;
                wave[c] = en[c] && (ph[c] < hi[c]);
            end
        end
    end

    // Scoreboard: every done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (m.done === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_done: got done=1, want no pending measurement");
            end else begin
                me = sb.pop_front();
                if (m.period_total !== me.ptot || m.high_total !== me.htot) begin
                    miscompares++;
                    $display("FAIL sb_totals: got period=%h high=%h, want period=%h high=%h",
                             m.period_total, m.high_total, me.ptot, me.htot);
                end
                vectors++;
                if (m.ch_valid !== me.valid || m.ch_timeout !== me.tout || m.ch_ovf !== me.ovf) begin
                    miscompares++;
                    $display("FAIL sb_flags: got valid=%b tout=%b ovf=%b, want valid=%b tout=%b ovf=%b",
                             m.ch_valid, m.ch_timeout, m.ch_ovf, me.valid, me.tout, me.ovf);
                end
            end
        end
    end

    task automatic setup(input int p0, input int h0, input int p1, input int h1, input bit e1);
        per[0] = p0; hi[0] = h0; per[1] = p1; hi[1] = h1; en[1] = e1;
        repeat (300) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [15:0] n, input exp_t e);
        @(negedge clk);
        m.start = 1'b1;
        m.n_cycles = n;
        sb.push_back(e);
        @(negedge clk);
        m.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int cyc);
        cyc = 0;
        while (m.done !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (m.done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_done: got done=0 after %0d clocks, want 1", nm, cyc);
        end
    endtask

    task automatic test_reset;
        repeat (4) @(negedge clk);
        vectors++;
        if ({m.busy, m.done, m.ch_valid, m.ch_timeout, m.ch_ovf} !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_flags: got busy=%b done=%b valid=%b tout=%b ovf=%b, want all 0",
                     m.busy, m.done, m.ch_valid, m.ch_timeout, m.ch_ovf);
        end
        vectors++;
        if (m.period_total !== 64'd0 || m.high_total !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_totals: got period=%h high=%h, want 0", m.period_total, m.high_total);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc;
        setup(100, 30, 250, 125, 1'b1);
        pulse_start(16'd4, '{{32'd1000, 32'd400}, {32'd500, 32'd120}, 2'b11, 2'b00, 2'b00});
        vectors++;
        if (m.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy: got %b, want 1", m.busy);
        end
        wait_done("basic", cyc);
        @(negedge clk);
        vectors++;
        if (m.done !== 1'b0 || m.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_pulse: got done=%b busy=%b, want 0 0", m.done, m.busy);
        end
    endtask

    task automatic test_n_zero;
        int cyc;
        setup(100, 30, 250, 125, 1'b1);
        pulse_start(16'd0, '{{32'd250, 32'd100}, {32'd125, 32'd30}, 2'b11, 2'b00, 2'b00});
        wait_done("n_zero", cyc);
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int cyc;
        setup(100, 30, 250, 125, 1'b0);
        pulse_start(16'd4, '{{32'd0, 32'd400}, {32'd0, 32'd120}, 2'b01, 2'b10, 2'b00});
        wait_done("timeout", cyc);
        vectors++;
        if (cyc < 4990 || cyc > 5010) begin
            miscompares++;
            $display("FAIL timeout_latency: got %0d clocks, want 4990..5010", cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int cyc;
        setup(100, 30, 250, 125, 1'b1);
        pulse_start(16'd4, '{{32'd1000, 32'd400}, {32'd500, 32'd120}, 2'b11, 2'b00, 2'b00});
        repeat (50) @(negedge clk);
        m.start = 1'b1;
        m.n_cycles = 16'd2;
        @(negedge clk);
        m.start = 1'b0;
        vectors++;
        if (m.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_busy_hold: got %b, want 1", m.busy);
        end
        wait_done("b2b_first", cyc);
        m.start = 1'b1;
        m.n_cycles = 16'd1;
        @(negedge clk);
        vectors++;
        if (m.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_start_on_done: got busy=%b, want 0", m.busy);
        end
        sb.push_back('{{32'd250, 32'd100}, {32'd125, 32'd30}, 2'b11, 2'b00, 2'b00});
        @(negedge clk);
        m.start = 1'b0;
        vectors++;
        if (m.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_start_after_done: got busy=%b, want 1", m.busy);
        end
        wait_done("b2b_second", cyc);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc;
        setup(100, 30, 250, 125, 1'b1);
        @(negedge clk);
        m.start = 1'b1;
        m.n_cycles = 16'd4;
        @(negedge clk);
        m.start = 1'b0;
        repeat (400) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({m.busy, m.done, m.ch_valid, m.ch_timeout, m.ch_ovf} !== 8'd0 ||
            m.period_total !== 64'd0 || m.high_total !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b period=%h, want all 0",
                     m.busy, m.done, m.period_total);
        end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            vectors++;
            if (m.done !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_no_done: got done=%b at clock %0d, want 0", m.done, k);
            end
        end
        pulse_start(16'd4, '{{32'd1000, 32'd400}, {32'd500, 32'd120}, 2'b11, 2'b00, 2'b00});
        wait_done("reset_mid_rerun", cyc);
        @(negedge clk);
    endtask

    task automatic test_ovf;
        int cyc;
        exp_t e;
        setup(100, 30, 250, 125, 1'b1);
        @(negedge clk);
        o.start = 1'b1;
        o.n_cycles = 16'd4;
        osb.push_back('{64'd255, 64'd120, 2'b01, 2'b00, 2'b01});
        @(negedge clk);
        o.start = 1'b0;
        cyc = 0;
        while (o.done !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (o.done !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_done: got done=0 after %0d clocks, want 1", cyc);
        end else begin
            e = osb.pop_front();
            if (o.period_total !== e.ptot[7:0] || o.high_total !== e.htot[7:0]) begin
                miscompares++;
                $display("FAIL ovf_totals: got period=%0d high=%0d, want period=%0d high=%0d",
                         o.period_total, o.high_total, e.ptot[7:0], e.htot[7:0]);
            end
            vectors++;
            if (o.ch_ovf !== e.ovf[0:0] || o.ch_valid !== e.valid[0:0] || o.ch_timeout !== e.tout[0:0]) begin
                miscompares++;
                $display("FAIL ovf_flags: got ovf=%b valid=%b tout=%b, want ovf=%b valid=%b tout=%b",
                         o.ch_ovf, o.ch_valid, o.ch_timeout, e.ovf[0:0], e.valid[0:0], e.tout[0:0]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        m.start = 1'b0;
        m.n_cycles = '0;
        o.start = 1'b0;
        o.n_cycles = '0;
        test_reset();
        test_basic();
        test_n_zero();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_ovf();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d pending results, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
